hls_deadlock_monitor_unit: RTL

Per-process deadlock monitor for HLS dataflow regions, successor to the per-process dependency-propagation unit. Propagates "waits-on" process sets along blocked channels and flags a deadlock when a process's own ID returns to it. Adds three capabilities:
- a stall-persistence filter, so transient back-pressure is not reported;
- a sticky detection state machine with a captured dependency snapshot;
- a bounded report-token relay.
One instance per dataflow process; instances are chained through the dependency and token vectors.

---
 rtl/hls_dl_pkg.sv | 28 ++
 rtl/hls_dl_stall_filter.sv | 31 +++
 rtl/hls_deadlock_monitor_unit.sv | 133 +++++++++++++
 3 files changed

// File: rtl/hls_dl_pkg.sv
// Shared types and elaboration helpers for the HLS dataflow deadlock monitor.
// Holds the FSM state encoding, own-ID mask helper and parameter legality checks.
package hls_dl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        DETECTED
    } dl_state_e;

    localparam int unsigned MAX_PROC = 64;

    function automatic logic [MAX_PROC-1:0] own_mask(input int unsigned id);
        logic [MAX_PROC-1:0] m;
        m = '0;
        m[id] = 1'b1;
        return m;
    endfunction

    function automatic bit proc_id_ok(input int unsigned num, input int unsigned id);
        return (num >= 1) && (num <= MAX_PROC) && (id < num);
    endfunction

    function automatic bit thresh_ok(input int unsigned thresh, input int unsigned w);
        return (thresh >= 1) && (w >= 1) && (w < 32) && (thresh <= ((1 << w) - 1));
    endfunction

endpackage

// File: rtl/hls_dl_stall_filter.sv
// Stall-persistence filter: saturating count of consecutive blocked cycles.
// stalled rises only once blocking has lasted STALL_THRESH cycles.
module hls_dl_stall_filter
    import hls_dl_pkg::*;
#(
    parameter int unsigned STALL_THRESH = 16,
    parameter int unsigned CNT_W        = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic blocked,
    output logic stalled
);

    localparam logic [CNT_W-1:0] THR = CNT_W'(STALL_THRESH);

    logic [CNT_W-1:0] stall_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (!blocked) begin
            stall_cnt <= '0;
        end else if (stall_cnt != THR) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign stalled = (stall_cnt == THR);

endmodule

// File: rtl/hls_deadlock_monitor_unit.sv
// Per-process deadlock monitor: propagates waits-on sets along blocked channels,
// latches a sticky detection with a dependency snapshot and relays report tokens.
module hls_deadlock_monitor_unit
    import hls_dl_pkg::*;
#(
    parameter int unsigned PROC_NUM     = 4,
    parameter int unsigned PROC_ID      = 0,
    parameter int unsigned IN_CHAN_NUM  = 2,
    parameter int unsigned OUT_CHAN_NUM = 3,
    parameter int unsigned STALL_THRESH = 16,
    parameter int unsigned CNT_W        = 8
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [OUT_CHAN_NUM-1:0]         proc_blk_vec,
    input  logic [IN_CHAN_NUM-1:0]          in_chan_dep_vld_vec,
    input  logic [IN_CHAN_NUM*PROC_NUM-1:0] in_chan_dep_data_vec,
    input  logic [IN_CHAN_NUM-1:0]          token_in_vec,
    input  logic                            origin,
    input  logic                            token_clear,
    input  logic                            dl_clear,
    output logic [OUT_CHAN_NUM-1:0]         out_chan_dep_vld_vec,
    output logic [PROC_NUM-1:0]             out_chan_dep_data,
    output logic [OUT_CHAN_NUM-1:0]         token_out_vec,
    output logic                            dl_detect_out,
    output logic                            dl_flag,
    output logic [PROC_NUM-1:0]             dl_snapshot
);

    if (!proc_id_ok(PROC_NUM, PROC_ID)) begin : g_bad_proc_id
        $error("hls_deadlock_monitor_unit: PROC_ID out of range");
    end
    if (!thresh_ok(STALL_THRESH, CNT_W)) begin : g_bad_thresh
        $error("hls_deadlock_monitor_unit: STALL_THRESH does not fit CNT_W");
    end

    localparam logic [PROC_NUM-1:0] OWN = PROC_NUM'(own_mask(PROC_ID));

    logic                stalled;
    logic                blocked;
    logic                accept;
    logic                det_cond;
    logic                tok_cond;
    logic [PROC_NUM-1:0] dep_comb;
    logic [PROC_NUM-1:0] dep;
    logic [PROC_NUM-1:0] dep_reg;
    dl_state_e           state;
    dl_state_e           state_nxt;

    assign blocked = |proc_blk_vec;

    hls_dl_stall_filter #(
        .STALL_THRESH (STALL_THRESH),
        .CNT_W        (CNT_W)
    ) u_filter (
        .clock   (clock),
        .reset   (reset),
        .blocked (blocked),
        .stalled (stalled)
    );

    always_comb begin
        dep_comb = '0;
        for (int i = 0; i < int'(IN_CHAN_NUM); i++) begin
            if (in_chan_dep_vld_vec[i]) begin
                dep_comb = dep_comb | in_chan_dep_data_vec[i*PROC_NUM +: PROC_NUM];
            end
        end
    end

    // Once flagged, only a token-carrying cycle may refresh the set.
    assign accept   = ~dl_flag | (|token_in_vec);
    assign dep      = accept ? dep_comb : dep_reg;
    assign det_cond = accept & dep[PROC_ID] & stalled;
    assign tok_cond = ((|token_in_vec) & ~token_clear) | origin;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dep_reg              <= '0;
            out_chan_dep_vld_vec <= '0;
            token_out_vec        <= '0;
        end else begin
            dep_reg              <= stalled ? dep : '0;
            out_chan_dep_vld_vec <= stalled ? proc_blk_vec : '0;
            token_out_vec        <= (tok_cond & stalled) ? proc_blk_vec : '0;
        end
    end

    assign out_chan_dep_data = dep_reg | OWN;

    always_comb begin
        state_nxt     = state;
        dl_detect_out = 1'b0;
        unique case (state)
            IDLE: begin
                if (stalled) state_nxt = ARMED;
            end
            ARMED: begin
                if (det_cond) begin
                    if (dl_clear) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt     = DETECTED;
                        dl_detect_out = 1'b1;
                    end
                end else if (!blocked) begin
                    state_nxt = IDLE;
                end
            end
            DETECTED: begin
                if (dl_clear) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            dl_snapshot <= '0;
        end else begin
            state <= state_nxt;
            if (dl_clear) begin
                dl_snapshot <= '0;
            end else if (dl_detect_out) begin
                dl_snapshot <= dep | OWN;
            end
        end
    end

    assign dl_flag = (state == DETECTED);

endmodule
